// File: rtl/axi_rd_arbiter.sv
// Two-master AXI3 read-channel arbiter: one outstanding read, grant held until the last R beat.
// Optional macro AXI_ARB_RR_EN selects round-robin tie-breaking; default is fixed priority (m1 wins).
module axi_rd_arbiter #(
    parameter logic [3:0] ID_M0    = 4'd0,
    parameter logic [3:0] ID_M1    = 4'd1,
    parameter logic [3:0] AR_CACHE = 4'b0000,
    parameter logic [2:0] AR_PROT  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_ar_valid,
    output logic        m0_ar_ready,
    input  logic [31:0] m0_ar_addr,
    input  logic [3:0]  m0_ar_len,
    input  logic [2:0]  m0_ar_size,
    input  logic [1:0]  m0_ar_burst,
    output logic        m0_r_valid,
    input  logic        m0_r_ready,
    output logic [31:0] m0_r_data,
    output logic [1:0]  m0_r_resp,
    output logic        m0_r_last,

    input  logic        m1_ar_valid,
    output logic        m1_ar_ready,
    input  logic [31:0] m1_ar_addr,
    input  logic [3:0]  m1_ar_len,
    input  logic [2:0]  m1_ar_size,
    input  logic [1:0]  m1_ar_burst,
    output logic        m1_r_valid,
    input  logic        m1_r_ready,
    output logic [31:0] m1_r_data,
    output logic [1:0]  m1_r_resp,
    output logic        m1_r_last,

    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    output logic [1:0]  ar_lock,
    output logic [3:0]  ar_cache,
    output logic [2:0]  ar_prot,
    output logic        ar_valid,
    input  logic        ar_ready,

    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic        r_valid,
    output logic        r_ready
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q;
    logic   grant_q;  // 0: m0, 1: m1
`ifdef AXI_ARB_RR_EN
    logic   last_grant_q;
`endif
    logic   req_any;
    logic   pick_m1;
    logic   accept;
    logic   in_data;
    logic   unused_r_id;

    assign req_any = m0_ar_valid | m1_ar_valid;

`ifdef AXI_ARB_RR_EN
    // On a tie the master that was not granted last time goes first.
    assign pick_m1 = m1_ar_valid & (~m0_ar_valid | ~last_grant_q);
`else
    assign pick_m1 = m1_ar_valid;
`endif

    assign accept      = (state_q == StIdle) & req_any & ~rst;
    assign m0_ar_ready = accept & ~pick_m1;
    assign m1_ar_ready = accept & pick_m1;

    // Only one read is ever outstanding, so every R beat belongs to the current grant.
    assign in_data     = (state_q == StData);
    assign m0_r_valid  = in_data & ~grant_q & r_valid;
    assign m1_r_valid  = in_data & grant_q & r_valid;
    assign r_ready     = in_data & (grant_q ? m1_r_ready : m0_r_ready);

    assign m0_r_data   = r_data;
    assign m0_r_resp   = r_resp;
    assign m0_r_last   = r_last;
    assign m1_r_data   = r_data;
    assign m1_r_resp   = r_resp;
    assign m1_r_last   = r_last;

    assign ar_lock     = 2'b00;
    assign ar_cache    = AR_CACHE;
    assign ar_prot     = AR_PROT;
    assign unused_r_id = ^r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
            ar_valid     <= 1'b0;
            ar_id        <= 4'd0;
            ar_addr      <= 32'd0;
            ar_len       <= 4'd0;
            ar_size      <= 3'd0;
            ar_burst     <= 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_q  <= pick_m1;
                        ar_valid <= 1'b1;
                        ar_id    <= pick_m1 ? ID_M1 : ID_M0;
                        ar_addr  <= pick_m1 ? m1_ar_addr : m0_ar_addr;
                        ar_len   <= pick_m1 ? m1_ar_len : m0_ar_len;
                        ar_size  <= pick_m1 ? m1_ar_size : m0_ar_size;
                        ar_burst <= pick_m1 ? m1_ar_burst : m0_ar_burst;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (r_valid & r_ready & r_last) begin
                        state_q      <= StIdle;
`ifdef AXI_ARB_RR_EN
                        last_grant_q <= grant_q;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed corner cases, then random traffic checked by a scoreboard
// fed from a transaction-level model of the arbitration policy.
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready, m0_r_last;
    logic [31:0] m0_ar_addr, m0_r_data;
    logic [3:0]  m0_ar_len;
    logic [2:0]  m0_ar_size;
    logic [1:0]  m0_ar_burst, m0_r_resp;
    logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready, m1_r_last;
    logic [31:0] m1_ar_addr, m1_r_data;
    logic [3:0]  m1_ar_len;
    logic [2:0]  m1_ar_size;
    logic [1:0]  m1_ar_burst, m1_r_resp;
    logic [3:0]  ar_id, ar_len, ar_cache, r_id;
    logic [31:0] ar_addr, r_data;
    logic [2:0]  ar_size, ar_prot;
    logic [1:0]  ar_burst, ar_lock, r_resp;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

    // Master R-ready: random per cycle in the random phase, directed otherwise.
    logic rdy_rand = 1'b0, m0_rdy_dir = 1'b1, m1_rdy_dir = 1'b1, m0_rnd = 1'b1, m1_rnd = 1'b1;
    assign m0_r_ready = rdy_rand ? m0_rnd : m0_rdy_dir;
    assign m1_r_ready = rdy_rand ? m1_rnd : m1_rdy_dir;
    always @(posedge clk) begin
        #1;
        m0_rnd = ($urandom_range(0, 3) != 0);
        m1_rnd = ($urandom_range(0, 3) != 0);
    end

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data),
        .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data),
        .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    int    vectors = 0;
    int    miscompares = 0;
    ar_t   exp_ar[$];
    beat_t exp_r0[$];
    beat_t exp_r1[$];
    int    slv_m[$];
    int    slv_len[$];
    int    cur_m = 0;
    logic  mon_en = 1'b0;
    logic  acc_prev = 1'b0;
    ar_t   mon_e;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (acc_prev) chk("ar_valid_after_accept", 64'(ar_valid), 64'd1);
            acc_prev = (m0_ar_valid & m0_ar_ready) | (m1_ar_valid & m1_ar_ready);
            chk("ar_ready_exclusive", 64'(m0_ar_ready & m1_ar_ready), 64'd0);
            if (ar_valid && ar_ready) begin
                if (exp_ar.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ar_request: got unexpected request addr 0x%0h, expected none",
                             ar_addr);
                end else begin
                    mon_e = exp_ar.pop_front();
                    chk("ar_request", 64'({ar_id, ar_addr, ar_len, ar_size, ar_burst}),
                        64'(mon_e));
                    chk("ar_constants", 64'({ar_lock, ar_cache, ar_prot}), 64'd0);
                end
            end
            chk("r_route", 64'({m1_r_valid, m0_r_valid}),
                !r_valid ? 64'd0 : (cur_m == 1 ? 64'd2 : 64'd1));
            if (m0_r_valid && m0_r_ready) begin
                if (exp_r0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL m0_r_beat: got unexpected beat 0x%0h, expected none", m0_r_data);
                end else begin
                    chk("m0_r_beat", 64'({m0_r_data, m0_r_resp, m0_r_last}),
                        64'(exp_r0.pop_front()));
                end
            end
            if (m1_r_valid && m1_r_ready) begin
                if (exp_r1.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL m1_r_beat: got unexpected beat 0x%0h, expected none", m1_r_data);
                end else begin
                    chk("m1_r_beat", 64'({m1_r_data, m1_r_resp, m1_r_last}),
                        64'(exp_r1.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        miscompares++;
        $display("FAIL watchdog: got no completion after 60000 cycles, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Directed helpers: a request that must be accepted in the cycle it is presented.
    task automatic req(input int m, input logic [31:0] a, input logic [3:0] l);
        if (m == 0) begin
            m0_ar_valid = 1'b1; m0_ar_addr = a; m0_ar_len = l; m0_ar_size = 3'd2;
            m0_ar_burst = 2'd1;
        end else begin
            m1_ar_valid = 1'b1; m1_ar_addr = a; m1_ar_len = l; m1_ar_size = 3'd2;
            m1_ar_burst = 2'd1;
        end
        @(negedge clk);
        chk("accept_ready", 64'({m1_ar_ready, m0_ar_ready}), (m == 0) ? 64'd1 : 64'd2);
        tick();
        m0_ar_valid = 1'b0;
        m1_ar_valid = 1'b0;
    endtask

    task automatic addr_now(input logic [3:0] id);
        ar_ready = 1'b1;
        @(negedge clk);
        chk("ar_valid_t+1", 64'({ar_valid, ar_id}), 64'({1'b1, id}));
        tick();
        ar_ready = 1'b0;
    endtask

    task automatic beat(input int m, input logic [31:0] d, input logic l);
        r_valid = 1'b1; r_data = d; r_last = l; r_resp = 2'b00;
        @(negedge clk);
        chk("beat_route", 64'({m1_r_valid, m0_r_valid}), (m == 0) ? 64'd1 : 64'd2);
        chk("beat_data", (m == 0) ? 64'({m0_r_data, m0_r_last}) : 64'({m1_r_data, m1_r_last}),
            64'({d, l}));
        tick();
        r_valid = 1'b0;
        r_last = 1'b0;
    endtask

    // Random-phase master: holds its request until accepted.
    task automatic issue(input int m, input logic [31:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b);
        logic rdy;
        if (m == 0) begin
            m0_ar_valid = 1'b1; m0_ar_addr = a; m0_ar_len = l; m0_ar_size = s; m0_ar_burst = b;
        end else begin
            m1_ar_valid = 1'b1; m1_ar_addr = a; m1_ar_len = l; m1_ar_size = s; m1_ar_burst = b;
        end
        do begin
            @(negedge clk);
            rdy = (m == 0) ? m0_ar_ready : m1_ar_ready;
            tick();
        end while (!rdy);
        if (m == 0) m0_ar_valid = 1'b0;
        else m1_ar_valid = 1'b0;
    endtask

    // Random-phase slave: serves n reads in model order, pushing each beat it sends.
    task automatic slave_serve(input int n);
        for (int k = 0; k < n; k++) begin
            int    m;
            int    len;
            logic  hs;
            beat_t bt;
            while (!ar_valid) tick();
            repeat ($urandom_range(0, 3)) tick();
            ar_ready = 1'b1;
            tick();
            ar_ready = 1'b0;
            m = slv_m.pop_front();
            len = slv_len.pop_front();
            cur_m = m;
            for (int b = 0; b <= len; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                bt.data = $urandom;
                bt.resp = 2'($urandom_range(0, 3));
                bt.last = (b == len);
                r_valid = 1'b1; r_data = bt.data; r_resp = bt.resp; r_last = bt.last;
                r_id = 4'(m);
                if (m == 0) exp_r0.push_back(bt);
                else exp_r1.push_back(bt);
                do begin
                    @(negedge clk);
                    hs = r_ready;
                    tick();
                end while (!hs);
                r_valid = 1'b0;
                r_last = 1'b0;
            end
        end
    endtask

    initial begin : main
        int          pat;
        int          first;
        int          n;
        int          m;
        int          model_last;
        int          order[2];
        logic [31:0] f_addr[2];
        logic [3:0]  f_len[2];
        logic [2:0]  f_size[2];
        logic [1:0]  f_burst[2];

        rst = 1'b1;
        m0_ar_valid = 1'b0; m0_ar_addr = '0; m0_ar_len = '0; m0_ar_size = '0; m0_ar_burst = '0;
        m1_ar_valid = 1'b0; m1_ar_addr = '0; m1_ar_len = '0; m1_ar_size = '0; m1_ar_burst = '0;
        ar_ready = 1'b0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b0; r_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 64'({ar_valid, r_ready, m0_ar_ready, m1_ar_ready, m0_r_valid,
                                m1_r_valid}), 64'd0);
        chk("rst_ar_regs", 64'({ar_id, ar_addr, ar_len, ar_size, ar_burst}), 64'd0);
        tick();

        // m0 alone, downstream stalls the address for 5 cycles
        req(0, 32'h1C00_0000, 4'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ar_stall_hold", 64'({ar_valid, ar_id, ar_addr, ar_len}),
                64'({1'b1, 4'd0, 32'h1C00_0000, 4'd3}));
            tick();
        end
        addr_now(4'd0);
        @(negedge clk);
        chk("ar_valid_drop", 64'({ar_valid, r_ready}), 64'd1);
        tick();
        for (int b = 0; b < 4; b++) beat(0, 32'(32'hA0 + b), (b == 3));

        // IDLE the cycle after the last beat; then reset after 2 of 4 beats
        req(0, 32'h2000_0040, 4'd3);
        addr_now(4'd0);
        beat(0, 32'hB0, 1'b0);
        beat(0, 32'hB1, 1'b0);
        rst = 1'b1; r_valid = 1'b1; r_data = 32'hB2;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_data", 64'({ar_valid, r_ready, m0_r_valid, m1_r_valid}), 64'd0);
        tick();
        r_valid = 1'b0;
        req(0, 32'h2000_0080, 4'd0);
        addr_now(4'd0);
        beat(0, 32'hC0, 1'b1);

        // m1 single beat with the master stalling for 3 cycles
        req(1, 32'h0000_1000, 4'd0);
        addr_now(4'd1);
        m1_rdy_dir = 1'b0; r_valid = 1'b1; r_last = 1'b1; r_data = 32'hD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_mirror", 64'({r_ready, m1_r_valid, m0_r_valid}), 64'b010);
            tick();
        end
        m1_rdy_dir = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'({r_ready, m1_r_valid, m1_r_data, m1_r_last}),
            64'({2'b11, 32'hD0, 1'b1}));
        tick();
        r_valid = 1'b0;
        r_last = 1'b0;
        req(0, 32'h3000_0000, 4'd0);
        addr_now(4'd0);
        beat(0, 32'hE0, 1'b1);

        // Random traffic against the scoreboard; the first two rounds are ties
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy_rand = 1'b1;
        mon_en = 1'b1;
        model_last = 1;
        for (int it = 0; it < 40; it++) begin
            pat = (it < 2) ? 3 : int'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                f_addr[k] = $urandom;
                f_len[k] = 4'($urandom_range(0, 7));
                f_size[k] = 3'($urandom_range(0, 2));
                f_burst[k] = 2'($urandom_range(0, 2));
            end
            if (pat == 3) begin
`ifdef AXI_ARB_RR_EN
                first = (model_last == 0) ? 1 : 0;
`else
                first = 1;
`endif
                order[0] = first;
                order[1] = 1 - first;
                n = 2;
            end else begin
                order[0] = (pat == 2) ? 1 : 0;
                n = 1;
            end
            for (int k = 0; k < n; k++) begin
                m = order[k];
                exp_ar.push_back(ar_t'({(m == 1) ? 4'd1 : 4'd0, f_addr[m], f_len[m], f_size[m],
                                        f_burst[m]}));
                slv_m.push_back(m);
                slv_len.push_back(int'(f_len[m]));
            end
            model_last = order[n - 1];
            fork
                begin
                    if (pat[0]) issue(0, f_addr[0], f_len[0], f_size[0], f_burst[0]);
                end
                begin
                    if (pat[1]) issue(1, f_addr[1], f_len[1], f_size[1], f_burst[1]);
                end
                slave_serve(n);
            join
            chk("sb_drained", 64'(exp_ar.size() + exp_r0.size() + exp_r1.size()), 64'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master AXI3 read-channel arbiter.
- Merges instruction-fetch (m0) and data-cache (m1) read requests onto the single read AR/R channel pair of the core's external AXI bus.
- Upstream of the top-level bus-to-pin mapping.
- One outstanding transaction at a time. The grant is held from address acceptance until the last read beat completes its handshake.

Parameters:
- ID_M0, 4'd0, ar_id driven for m0 transactions
- ID_M1, 4'd1, ar_id driven for m1 transactions
- AR_CACHE, 4'b0000, constant ar_cache value
- AR_PROT, 3'b000, constant ar_prot value

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mN_ar_valid  in  1  master N read request, N = 0/1 (per-master ports repeat for m0 and m1)
- mN_ar_ready  out  1  request accepted
- mN_ar_addr  in  32  read address
- mN_ar_len  in  4  beats minus 1
- mN_ar_size  in  3  beat size
- mN_ar_burst  in  2  burst type
- mN_r_valid  out  1  read beat valid to master N
- mN_r_ready  in  1  master N ready for beat
- mN_r_data  out  32  beat data (shared bus, valid only when mN_r_valid)
- mN_r_resp  out  2  beat response
- mN_r_last  out  1  last beat
- ar_id  out  4  downstream request id
- ar_addr  out  32  downstream address
- ar_len  out  4  downstream length
- ar_size  out  3  downstream size
- ar_burst  out  2  downstream burst
- ar_lock  out  2  constant 2'b00
- ar_cache  out  4  constant AR_CACHE
- ar_prot  out  3  constant AR_PROT
- ar_valid  out  1  downstream request valid
- ar_ready  in  1  downstream request accepted
- r_id  in  4  downstream beat id
- r_data  in  32  downstream beat data
- r_resp  in  2  downstream beat response
- r_last  in  1  downstream last beat
- r_valid  in  1  downstream beat valid
- r_ready  out  1  downstream beat ready

Behaviour:
- States: IDLE, ADDR, DATA. Reset state is IDLE.
- Reset values: ar_valid=0, ar_addr/ar_len/ar_size/ar_burst/ar_id=0, grant=0, last_grant=1, r_ready=0, all mN_ar_ready=0, all mN_r_valid=0.
- IDLE:
  - Arbitrate among the asserted mN_ar_valid; mN_ar_ready=1 combinationally for the winner only.
  - The winner's ar_addr/len/size/burst and ar_id (ID_M0 or ID_M1) are registered and grant is stored.
  - Next state is ADDR. If no request, stay in IDLE.
- ADDR:
  - ar_valid=1 and all ar_* held stable until ar_ready=1.
  - On the handshake cycle, ar_valid drops next cycle and the state moves to DATA.
  - mN_ar_ready=0 for both masters.
- DATA:
  - Granted master: mN_r_valid=r_valid, r_ready=mN_r_ready; mN_r_data/resp/last pass through combinationally.
  - Non-granted master: mN_r_valid=0.
  - r_valid & r_ready & r_last: state goes to IDLE next cycle and last_grant <= grant.
  - r_id is not checked; the single outstanding transaction guarantees the beat belongs to the granted master.
- Latency:
  - Request accepted in cycle t gives ar_valid in cycle t+1.
  - Last beat handshaked in cycle t gives IDLE in t+1; a new acceptance is possible in t+1.
  - Minimum turnaround is 1 idle cycle between transactions.
- Masters hold request fields stable while mN_ar_valid=1 and not ready (AXI rule); the arbiter does not re-check them after capture.
- Simultaneous requests are resolved per the arbitration policy (see Optional Feature). A request that loses stays pending with no ready.
- A master deasserting mN_ar_valid before acceptance is permitted; the arbiter only samples requests in IDLE.
- Single-beat burst (len=0): the first R beat has r_last=1, giving DATA for one handshake cycle and then IDLE.
- r_valid with r_ready=0 (master stall): the beat is held by the downstream slave; the arbiter adds no buffering.
- rst asserted in any state: next cycle IDLE with all outputs at reset values. An in-flight downstream transaction is abandoned, and the bus slave is reset from the same source.

Optional Feature:
- Macro: AXI_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the master not equal to last_grant wins. last_grant resets to 1, so m0 wins the first tie.
- Undefined: fixed priority, m1 (data) always wins a tie. The last_grant register is removed.

Test Plan:
- Only m0 requests addr 0x1C000000, len=3. Expect ar_valid at t+1 with ar_id=0, ar_len=3. Slave returns 4 beats 0xA0..0xA3 with rlast on the 4th. m0 receives all 4 beats and m1_r_valid stays 0. IDLE is reached the cycle after the last beat.
- m0 and m1 request in the same cycle, fixed priority. m1 (addr 0x0000_1000) is granted first with ar_id=1, m1_ar_ready=1 and m0_ar_ready=0. After m1's rlast, m0 is accepted one cycle later.
- Same stimulus with AXI_ARB_RR_EN: m0 is granted first, then m1. Repeat the pair: grants alternate m0, m1, m0, m1.
- ar_ready held low for 5 cycles. ar_valid stays 1 and ar_addr/ar_len stay unchanged for all 5 cycles. The handshake occurs on cycle 6.
- m1 len=0 read with m1_r_ready low for 3 cycles while r_valid=1. r_ready=0 is mirrored for those cycles. A single beat with r_last completes on the 4th cycle and the arbiter returns to IDLE.
- rst pulsed for one cycle while in DATA after 2 of 4 beats. Next cycle: ar_valid=0, r_ready=0, mN_r_valid=0, state IDLE, and a new m0 request is accepted normally.
